// File: rtl/spike_array_driver.sv
// spike_array_driver
//   Initiator side of the spike array compute interface. A batch of cmd_len
//   activation vectors is accepted on the s_* stream. Each accepted vector is
//   issued to the array with a single-cycle arr_start. The array answers every
//   start with an arr_done/arr_result pair, in order and with no backpressure.
//   Results are queued in a FWFT FIFO and returned on the m_* stream.
//
//   The array cannot be stalled, so vectors are only accepted while
//   (in-flight + queued + about-to-issue) is below FIFO_DEPTH. Every result
//   therefore has a FIFO slot waiting for it.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   cmd_start/cmd_len  batch start pulse and vector count (IDLE only)
//   w_load/w_data      weight register load (IDLE only)
//   s_valid/s_ready/s_data       activation vector stream in
//   arr_start/arr_weights_flat/arr_acts_flat  issue side to the array
//   arr_done/arr_result          result side from the array
//   m_valid/m_ready/m_data/m_last  result stream out, m_last on the final result
//   busy               high while a batch is in RUN or DRAIN
module spike_array_driver #(
    parameter int N          = 128,
    parameter int BITWIDTH   = 4,
    parameter int BATCH_NUM  = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic [10:0]           cmd_len,
    input  logic                  w_load,
    input  logic [N*4-1:0]        w_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [N*BITWIDTH-1:0] s_data,
    output logic                  arr_start,
    output logic [N*4-1:0]        arr_weights_flat,
    output logic [N*BITWIDTH-1:0] arr_acts_flat,
    input  logic                  arr_done,
    input  logic [15:0]           arr_result,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [15:0]           m_data,
    output logic                  m_last,
    output logic                  busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [10:0] LEN_MAX    = 11'(BATCH_NUM);
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [N*4-1:0]  w_reg;
    logic [10:0]     issue_cnt, ret_cnt;
    logic [CW-1:0]   outstanding, fifo_count;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [CW:0]     credit_used;
    logic            active, len_ok, s_hs, fifo_wr, fifo_rd, done_ok;

    assign active           = (state == RUN) || (state == DRAIN);
    assign busy             = active;
    assign arr_weights_flat = w_reg;
    assign len_ok           = (cmd_len != 11'd0) && (cmd_len <= LEN_MAX);

    // arr_start is included because a vector accepted last cycle is being
    // issued now but is not yet counted in outstanding.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count} + {{CW{1'b0}}, arr_start};
    assign s_ready     = (state == RUN) && (issue_cnt != 11'd0) && (credit_used < CREDIT_MAX);
    assign s_hs        = s_valid && s_ready;

    assign fifo_wr = arr_done && active && (ret_cnt != 11'd0);
    assign m_valid = (fifo_count != '0);
    assign fifo_rd = m_valid && m_ready;
    assign m_data  = mem[rd_ptr];
    assign m_last  = (ret_cnt == 11'd0) && (fifo_count == CW'(1));

    // Stale completions after a reset must not wrap the counter below zero.
    assign done_ok = arr_done && (outstanding != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_start && len_ok) state_nxt = RUN;
            RUN:     if (s_hs && issue_cnt == 11'd1) state_nxt = DRAIN;
            DRAIN:   if (ret_cnt == 11'd0 && fifo_count == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            issue_cnt     <= '0;
            ret_cnt       <= '0;
            outstanding   <= '0;
            w_reg         <= '0;
            arr_start     <= 1'b0;
            arr_acts_flat <= '0;
        end else begin
            state     <= state_nxt;
            arr_start <= s_hs;
            if (s_hs) arr_acts_flat <= s_data;
            if (state == IDLE && w_load) w_reg <= w_data;
            if (state == IDLE && cmd_start && len_ok) begin
                issue_cnt <= cmd_len;
                ret_cnt   <= cmd_len;
            end else begin
                if (s_hs)    issue_cnt <= issue_cnt - 11'd1;
                if (fifo_wr) ret_cnt   <= ret_cnt - 11'd1;
            end
            case ({arr_start, done_ok})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= arr_result;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_wr && !fifo_rd && fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_spike_array_driver.sv
module tb_spike_array_driver;
    localparam int N  = 128;
    localparam int BW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_start;
    logic [10:0]       cmd_len;
    logic              w_load;
    logic [N*4-1:0]    w_data;
    logic              s_valid;
    logic              s_ready;
    logic [N*BW-1:0]   s_data;
    logic              arr_start;
    logic [N*4-1:0]    arr_weights_flat;
    logic [N*BW-1:0]   arr_acts_flat;
    logic              arr_done;
    logic [15:0]       arr_result;
    logic              m_valid;
    logic              m_ready;
    logic [15:0]       m_data;
    logic              m_last;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int lat     = 10;
    bit idx_mode = 1'b0;
    int n_start = 0;
    int base    = 0;
    int tb_out  = 0;
    int max_out = 0;
    int hs_first = 0;
    bit rand_ready = 1'b0;
    bit ready_en   = 1'b1;
    int          due_q[$];
    logic [15:0] res_q[$];
    int          st_cyc[$];
    logic [15:0] rq_data[$];
    bit          rq_last[$];

    spike_array_driver #(.N(N), .BITWIDTH(BW), .BATCH_NUM(1024), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_len(cmd_len),
        .w_load(w_load), .w_data(w_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .arr_start(arr_start), .arr_weights_flat(arr_weights_flat),
        .arr_acts_flat(arr_acts_flat), .arr_done(arr_done), .arr_result(arr_result),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] dot16(input logic [N*4-1:0] w, input logic [N*BW-1:0] a);
        int acc = 0;
        for (int i = 0; i < N; i++)
            acc += int'($signed(w[i*4 +: 4])) * int'($signed(a[i*BW +: BW]));
        return 16'(acc);
    endfunction

    // Array model: fixed latency, in-order, no backpressure. Results are the
    // dot product, or the per-batch vector index in idx_mode.
    initial begin
        arr_done = 1'b0;
        arr_result = '0;
        forever begin
            @(negedge clk);
            if (rst) tb_out = 0;
            else begin
                tb_out = tb_out + int'(arr_start) - int'(arr_done);
                if (tb_out < 0) tb_out = 0;
            end
            if (tb_out > max_out) max_out = tb_out;
            if (arr_start) begin
                st_cyc.push_back(cyc);
                due_q.push_back(cyc + lat);
                res_q.push_back(idx_mode ? 16'(n_start - base) : dot16(arr_weights_flat, arr_acts_flat));
                n_start++;
            end
            arr_done = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                arr_done = 1'b1;
                arr_result = res_q.pop_front();
                void'(due_q.pop_front());
            end
        end
    end

    // Result collector; m_ready is chosen before the sample so the recorded
    // beat is the one the next rising edge consumes.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_en;
            if (m_valid && m_ready) begin
                rq_data.push_back(m_data);
                rq_last.push_back(m_last);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, summary %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic do_cmd(input logic [10:0] len);
        base = n_start;
        @(negedge clk); cmd_len = len; cmd_start = 1'b1;
        @(negedge clk); cmd_start = 1'b0;
    endtask

    task automatic load_w(input logic [N*4-1:0] d);
        @(negedge clk); w_data = d; w_load = 1'b1;
        @(negedge clk); w_load = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps, input logic [BW-1:0] lane);
        int t;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) begin s_valid = 1'b0; @(negedge clk); end
            s_valid = 1'b1;
            s_data = {N{lane}};
            t = 0;
            while (!s_ready && !rst && t < 20000) begin @(negedge clk); t++; end
            if (rst || t >= 20000) begin s_valid = 1'b0; return; end
            if (i == 0) hs_first = cyc + 1;
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_res(input int n, input int budget);
        int t = 0;
        while (rq_data.size() < n && t < budget) begin @(negedge clk); t++; end
    endtask

    task automatic clear_q();
        rq_data.delete();
        rq_last.delete();
        st_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
        n_total++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b, expected 0", s_ready); else n_pass++;
        n_total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b, expected 0", m_valid); else n_pass++;
        n_total++; if (arr_start !== 1'b0) $display("FAIL reset_arr_start: got %b, expected 0", arr_start); else n_pass++;
        n_total++; if (arr_weights_flat !== '0) $display("FAIL reset_weights: got %h, expected 0", arr_weights_flat); else n_pass++;
        n_total++; if (arr_acts_flat !== '0) $display("FAIL reset_acts: got %h, expected 0", arr_acts_flat); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_q();
        idx_mode = 1'b0; lat = 10; rand_ready = 1'b0; ready_en = 1'b1;
        load_w({N{4'h1}});
        do_cmd(11'd4);
        feed(4, 1'b0, 4'h1);
        wait_res(4, 200);
        n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_at_last: got %b, expected 1", busy); else n_pass++;
        n_total++; if (st_cyc.size() != 4) $display("FAIL basic_start_count: got %0d, expected 4", st_cyc.size()); else n_pass++;
        if (st_cyc.size() == 4) begin
            n_total++; if (st_cyc[0] != hs_first) $display("FAIL basic_start_latency: got cycle %0d, expected %0d", st_cyc[0], hs_first); else n_pass++;
            n_total++; if (st_cyc[3] - st_cyc[0] != 3) $display("FAIL basic_start_back_to_back: got span %0d, expected 3", st_cyc[3] - st_cyc[0]); else n_pass++;
        end
        n_total++; if (arr_acts_flat !== {N{4'h1}}) $display("FAIL basic_acts: got %h, expected all lanes 1", arr_acts_flat); else n_pass++;
        n_total++; if (rq_data.size() != 4) $display("FAIL basic_result_count: got %0d, expected 4", rq_data.size()); else n_pass++;
        for (int i = 0; i < rq_data.size(); i++) begin
            n_total++; if (rq_data[i] !== 16'd128) $display("FAIL basic_data[%0d]: got %0d, expected 128", i, rq_data[i]); else n_pass++;
            n_total++; if (rq_last[i] !== (i == 3)) $display("FAIL basic_last[%0d]: got %b, expected %b", i, rq_last[i], (i == 3)); else n_pass++;
        end
        repeat (2) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b, expected 0", busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad = -1;
        int nlast = 0;
        clear_q();
        idx_mode = 1'b1; lat = 10; rand_ready = 1'b0; ready_en = 1'b0; max_out = 0;
        do_cmd(11'd40);
        fork feed(40, 1'b0, 4'h3); join_none
        repeat (60) @(negedge clk);
        n_total++; if (st_cyc.size() != 16) $display("FAIL bp_starts_held: got %0d, expected 16", st_cyc.size()); else n_pass++;
        n_total++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready_held: got %b, expected 0", s_ready); else n_pass++;
        n_total++; if (m_valid !== 1'b1) $display("FAIL bp_m_valid_held: got %b, expected 1", m_valid); else n_pass++;
        n_total++; if (m_data !== 16'd0) $display("FAIL bp_head_held: got %0d, expected 0", m_data); else n_pass++;
        ready_en = 1'b1;
        wait_res(40, 2000);
        repeat (5) @(negedge clk);
        n_total++; if (rq_data.size() != 40) $display("FAIL bp_count: got %0d, expected 40", rq_data.size()); else n_pass++;
        for (int i = 0; i < rq_data.size(); i++) begin
            if (rq_data[i] !== 16'(i) && bad < 0) bad = i;
            if (rq_last[i]) nlast++;
        end
        n_total++; if (bad >= 0) $display("FAIL bp_order: index %0d got %0d, expected %0d", bad, rq_data[bad], bad); else n_pass++;
        n_total++; if (nlast != 1) $display("FAIL bp_last_count: got %0d, expected 1", nlast); else n_pass++;
        n_total++; if (max_out > 16) $display("FAIL bp_outstanding: got %0d, expected <= 16", max_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL bp_busy_end: got %b, expected 0", busy); else n_pass++;
    endtask

    task automatic test_random(input int l);
        int bad = -1;
        int last_pos = -1;
        int nlast = 0;
        int t = 0;
        clear_q();
        idx_mode = 1'b1; lat = l; rand_ready = 1'b1; max_out = 0;
        do_cmd(11'd1024);
        fork feed(1024, 1'b1, 4'h2); join_none
        wait_res(1024, 30000);
        rand_ready = 1'b0; ready_en = 1'b1;
        while (busy && t < 40) begin @(negedge clk); t++; end
        n_total++; if (rq_data.size() != 1024) $display("FAIL rand_l%0d_count: got %0d, expected 1024", l, rq_data.size()); else n_pass++;
        for (int i = 0; i < rq_data.size(); i++) begin
            if (rq_data[i] !== 16'(i) && bad < 0) bad = i;
            if (rq_last[i]) begin nlast++; last_pos = i; end
        end
        n_total++; if (bad >= 0) $display("FAIL rand_l%0d_order: index %0d got %0d, expected %0d", l, bad, rq_data[bad], bad); else n_pass++;
        n_total++; if (nlast != 1 || last_pos != 1023) $display("FAIL rand_l%0d_last: got %0d flags at %0d, expected 1 at 1023", l, nlast, last_pos); else n_pass++;
        n_total++; if (max_out > 16) $display("FAIL rand_l%0d_outstanding: got %0d, expected <= 16", l, max_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rand_l%0d_busy_end: got %b, expected 0", l, busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t = 0;
        clear_q();
        idx_mode = 1'b1; lat = 10; rand_ready = 1'b0; ready_en = 1'b1;
        do_cmd(11'd10);
        fork feed(10, 1'b0, 4'h1); join_none
        while ((n_start - base) < 5 && t < 200) begin @(negedge clk); t++; end
        rst = 1'b1;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b, expected 0", busy); else n_pass++;
        n_total++; if (s_ready !== 1'b0) $display("FAIL rmid_s_ready: got %b, expected 0", s_ready); else n_pass++;
        n_total++; if (m_valid !== 1'b0) $display("FAIL rmid_m_valid: got %b, expected 0", m_valid); else n_pass++;
        n_total++; if (arr_start !== 1'b0) $display("FAIL rmid_arr_start: got %b, expected 0", arr_start); else n_pass++;
        n_total++; if (arr_acts_flat !== '0) $display("FAIL rmid_acts: got %h, expected 0", arr_acts_flat); else n_pass++;
        n_total++; if (arr_weights_flat !== '0) $display("FAIL rmid_weights: got %h, expected 0", arr_weights_flat); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_q();
        repeat (30) @(negedge clk);
        n_total++; if (rq_data.size() != 0) $display("FAIL rmid_stale_results: got %0d, expected 0", rq_data.size()); else n_pass++;
        do_cmd(11'd2);
        feed(2, 1'b0, 4'h1);
        wait_res(2, 200);
        repeat (20) @(negedge clk);
        n_total++; if (rq_data.size() != 2) $display("FAIL rmid_new_count: got %0d, expected 2", rq_data.size()); else n_pass++;
        if (rq_data.size() == 2) begin
            n_total++; if (rq_data[0] !== 16'd0 || rq_data[1] !== 16'd1) $display("FAIL rmid_new_data: got %0d,%0d, expected 0,1", rq_data[0], rq_data[1]); else n_pass++;
            n_total++; if (rq_last[0] !== 1'b0 || rq_last[1] !== 1'b1) $display("FAIL rmid_new_last: got %b%b, expected 01", rq_last[0], rq_last[1]); else n_pass++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy_end: got %b, expected 0", busy); else n_pass++;
    endtask

    task automatic test_ignored();
        clear_q();
        do_cmd(11'd0);
        repeat (2) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL ign_len0_busy: got %b, expected 0", busy); else n_pass++;
        n_total++; if (s_ready !== 1'b0) $display("FAIL ign_len0_s_ready: got %b, expected 0", s_ready); else n_pass++;
        do_cmd(11'd1025);
        repeat (2) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL ign_len1025_busy: got %b, expected 0", busy); else n_pass++;
        idx_mode = 1'b0; lat = 10; ready_en = 1'b1;
        load_w({N{4'h1}});
        do_cmd(11'd2);
        n_total++; if (busy !== 1'b1) $display("FAIL ign_run_busy: got %b, expected 1", busy); else n_pass++;
        load_w({N{4'h2}});
        n_total++; if (arr_weights_flat !== {N{4'h1}}) $display("FAIL ign_wload_in_run: got %h, expected all lanes 1", arr_weights_flat); else n_pass++;
        do_cmd(11'd5);
        feed(2, 1'b0, 4'h1);
        wait_res(2, 200);
        repeat (5) @(negedge clk);
        n_total++; if (rq_data.size() != 2) $display("FAIL ign_count: got %0d, expected 2", rq_data.size()); else n_pass++;
        if (rq_data.size() == 2) begin
            n_total++; if (rq_data[1] !== 16'd128) $display("FAIL ign_data: got %0d, expected 128", rq_data[1]); else n_pass++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL ign_busy_end: got %b, expected 0", busy); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; cmd_start = 1'b0; cmd_len = '0; w_load = 1'b0;
        w_data = '0; s_valid = 1'b0; s_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_random(10);
        test_random(3);
        test_random(25);
        test_reset_mid();
        test_ignored();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
